// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter, LSB first, one byte per valid/ready handshake.
// The serial line and the done pulse are registered so tx never glitches.
module uart_byte_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (tx_valid) begin
                    shift_d   = tx_data;
                    bit_idx_d = 3'd0;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    // The next line level is the bit about to become shift[0].
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Registered pulse: raise it one count early so it is high on the final stop clock.
                done_d = (cnt_q == CNT_PRE);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = !tx_ready;
    assign tx       = tx_q;
    assign tx_done  = done_q;

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serial UART transmitter, 8N1, LSB first, for the UART text/display lessons. Accepts one byte per valid/ready handshake from upstream logic (key scan, counter or echo path) and shifts it out on the `tx` line at a parameterised baud rate. It is the transmit counterpart of the board's UART receive path, so a byte sent here can be looped back and shown on the two-digit seven-segment display.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency, Hz.
- `BAUD`, default 9600: line rate, bit/s.
- `BAUD_DIV`, default CLK_FREQ/BAUD (5208): clocks per bit, integer-truncated. Must be >= 2.

Ports:
- `clk` input 1: system clock, rising edge. `rst_n` is asynchronous and active-low; `clk` is the clock.
- `rst_n` input 1: asynchronous active-low reset.
- `tx_data` input 8: byte to send. Sampled only on the handshake cycle.
- `tx_valid` input 1: upstream has a byte available.
- `tx_ready` output 1: block can accept a byte this cycle.
- `tx` output 1: serial line, idle high, registered.
- `tx_busy` output 1: frame in progress (START, DATA or STOP state).
- `tx_done` output 1: one-cycle pulse on the last clock of the stop bit.

## Operation
- States:
  - IDLE: `tx`=1, `tx_ready`=1. On `tx_valid && tx_ready`, latch `tx_data` into the shift register, clear the baud counter and the bit index, and go to START.
  - START: `tx`=0 for BAUD_DIV clocks, then go to DATA.
  - DATA: `tx`=shift[0] for BAUD_DIV clocks per bit. Shift right after each bit. Bit index runs 0..7. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for BAUD_DIV clocks. `tx_done`=1 on the final clock, then go to IDLE.
- Baud counter:
  - Width is $clog2(BAUD_DIV).
  - Counts 0..BAUD_DIV-1 and wraps to 0 at the bit boundary.
  - Active only outside IDLE; held at 0 in IDLE.
- Bit index is 3 bits. Its terminal value 7 is detected together with the counter at BAUD_DIV-1. No wrap-around beyond 7 is allowed.
- `tx_ready` = (state==IDLE). `tx_busy` = !tx_ready.
- Inputs ignored while busy:
  - `tx_data` changes have no effect on the frame in flight.
  - `tx_valid` has no effect; there is no queuing, so the upstream holds `tx_valid` until the handshake.
- `tx` is driven from a flop so the line never glitches.
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously: `tx` goes to 1 and state to IDLE. No `tx_done` is produced for the aborted byte.

## Timing
- Let H be the handshake cycle (clock edge where `tx_valid && tx_ready`).
- Start bit: `tx` falls after edge H and stays low for BAUD_DIV clocks.
- Data bit k occupies clocks H+1+BAUD_DIV*(k+1) through H+BAUD_DIV*(k+2).
- Stop bit occupies clocks H+1+9*BAUD_DIV through H+10*BAUD_DIV. `tx_done` is high on clock H+10*BAUD_DIV.
- `tx_ready` rises after the `tx_done` clock. The earliest next handshake is H+10*BAUD_DIV+1.
- Back-to-back period with `tx_valid` held high: 10*BAUD_DIV+1 clocks. There is exactly one extra idle-high clock between frames.
- Bit-period error comes only from the BAUD_DIV truncation. There is no cumulative drift within a frame.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs -> `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; no handshake occurs while in reset.
- **Single byte:** CLK_FREQ=16, BAUD=1 (BAUD_DIV=16), send 0x55 -> `tx` sequence 0,1,0,1,0,1,0,1,0,1, each level exactly 16 clocks. `tx_done` pulses once, on clock H+160. `tx_ready` is high at H+161.
- **Back-to-back:** `tx_valid` held, 0xA5 then 0x3C -> bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 (LSB first). The second start bit begins exactly 161 clocks after the first.
- **Busy-time stimulus:** during 0x0F, change `tx_data` to 0xF0 and pulse `tx_valid` mid-frame -> transmitted byte decodes as 0x0F. No second frame starts unless `tx_valid` is high while `tx_ready`=1.
- **Reset mid-frame:** reset during data bit 3 of 0x81 -> `tx`=1 asynchronously and no `tx_done`. After release, 0x81 sends cleanly with correct timing.
- **Loopback:** default parameters, connect `tx` to the UART receiver and send 0x00, 0x2A, 0xFF -> receiver outputs 0x00, 0x2A, 0xFF. Frame length is 52081 clocks each.
